// File: rtl/fir_chan_sched.sv
// Time-division scheduler sharing one serial MAC FIR datapath among NUM_CH channels.
// Define FIXED_PRIO_EN for lowest-index-wins arbitration; default build is round-robin.
module fir_chan_sched #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned NUM_COEF = 17,
  parameter int unsigned LAT      = 3,
  localparam int unsigned CW      = $clog2(NUM_CH),
  localparam int unsigned AW      = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic              shift_en,
  output logic [CW-1:0]     ch_sel,
  output logic [AW-1:0]     addr,
  output logic              acc_rst,
  output logic              acc_ce,
  output logic              busy,
  output logic              val_out,
  output logic [CW-1:0]     ch_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StMac   = 2'd2;

  localparam logic [AW-1:0] LastAddr = AW'(NUM_COEF - 1);
  localparam logic [CW-1:0] LastCh   = CW'(NUM_CH - 1);

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              shift_en_q, shift_en_d;
  logic [CW-1:0]     ch_sel_q, ch_sel_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              tap_vld_d, tap_first_d, tap_last_d;

  // Stage 0 of each pipe is the tap flag itself, aligned with addr.
  logic [LAT:0]      vld_pipe_q, first_pipe_q;
  logic [LAT+1:0]    last_pipe_q;
  logic [CW-1:0]     ch_pipe_q [LAT+1:1];

  logic [CW-1:0]     win;

`ifdef FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) win = CW'(i);
    end
  end
`else
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] cand;

  // Descending scan so the smallest offset from rr_q is the last (winning) assignment.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CW'((int'(rr_q) + i) % NUM_CH);
      if (req[cand]) win = cand;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    shift_en_d  = 1'b0;
    ch_sel_d    = ch_sel_q;
    addr_d      = '0;
    tap_vld_d   = 1'b0;
    tap_first_d = 1'b0;
    tap_last_d  = 1'b0;
`ifndef FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StGrant;
          gnt_d      = NUM_CH'(1) << win;
          shift_en_d = 1'b1;
          ch_sel_d   = win;
`ifndef FIXED_PRIO_EN
          rr_d       = (win == LastCh) ? '0 : win + 1'b1;
`endif
        end
      end
      StGrant: begin
        state_d     = StMac;
        tap_vld_d   = 1'b1;
        tap_first_d = 1'b1;
        tap_last_d  = (NUM_COEF == 1);
      end
      StMac: begin
        if (addr_q == LastAddr) begin
          state_d = StIdle;
        end else begin
          addr_d     = addr_q + 1'b1;
          tap_vld_d  = 1'b1;
          tap_last_d = ((addr_q + 1'b1) == LastAddr);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      shift_en_q   <= 1'b0;
      ch_sel_q     <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      for (int i = 1; i <= int'(LAT) + 1; i++) ch_pipe_q[i] <= '0;
`ifndef FIXED_PRIO_EN
      rr_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      shift_en_q      <= shift_en_d;
      ch_sel_q        <= ch_sel_d;
      addr_q          <= addr_d;
      busy_q          <= busy_d;
      vld_pipe_q[0]   <= tap_vld_d;
      first_pipe_q[0] <= tap_first_d;
      last_pipe_q[0]  <= tap_last_d;
      for (int i = 1; i <= int'(LAT); i++) begin
        vld_pipe_q[i]   <= vld_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
      end
      for (int i = 1; i <= int'(LAT) + 1; i++) last_pipe_q[i] <= last_pipe_q[i-1];
      ch_pipe_q[1] <= ch_sel_q;
      for (int i = 2; i <= int'(LAT) + 1; i++) ch_pipe_q[i] <= ch_pipe_q[i-1];
`ifndef FIXED_PRIO_EN
      rr_q            <= rr_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign shift_en = shift_en_q;
  assign ch_sel   = ch_sel_q;
  assign addr     = addr_q;
  assign busy     = busy_q;
  assign acc_ce   = vld_pipe_q[LAT];
  assign acc_rst  = first_pipe_q[LAT];
  assign val_out  = last_pipe_q[LAT+1];
  assign ch_out   = ch_pipe_q[LAT+1];

endmodule

// File: tb/tb_fir_chan_sched.sv
// Scoreboard bench for fir_chan_sched: expected grants/results queued at stimulus time.
// Honours FIXED_PRIO_EN the same way as the design.
module tb_fir_chan_sched;

  localparam int NumCh   = 4;
  localparam int NumCoef = 17;
  localparam int Lat     = 3;
  localparam int Period  = NumCoef + 2;
  localparam int ValDly  = NumCoef + Lat + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       shift_en, acc_rst, acc_ce, busy, val_out;
  logic [1:0] ch_sel, ch_out;
  logic [4:0] addr;

  fir_chan_sched #(
    .NUM_CH   (NumCh),
    .NUM_COEF (NumCoef),
    .LAT      (Lat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .shift_en (shift_en),
    .ch_sel   (ch_sel),
    .addr     (addr),
    .acc_rst  (acc_rst),
    .acc_ce   (acc_ce),
    .busy     (busy),
    .val_out  (val_out),
    .ch_out   (ch_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_gnt[$];
  int         exp_gidx[$];
  int         exp_ch[$];
  int         exp_at[$];
  int         mrr = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    int w = 0;
`ifdef FIXED_PRIO_EN
    for (int i = NumCh - 1; i >= 0; i--) if (r[i]) w = i;
`else
    for (int i = NumCh - 1; i >= 0; i--) if (r[(ptr + i) % NumCh]) w = (ptr + i) % NumCh;
`endif
    return w;
  endfunction

  // Predict n successive grants for a request pattern held across passes.
  task automatic push_grants(input logic [3:0] r, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = pick(r, mrr);
      exp_gnt.push_back(4'b0001 << w);
      exp_gidx.push_back(w);
      mrr = (w + 1) % NumCh;
    end
  endtask

  logic [3:0] mon_eg;
  int         mon_k, mon_ch, mon_at;

  always @(negedge clk) begin
    if (gnt != 4'b0000) begin
      if (exp_gnt.size() == 0) begin
        check_eq("gnt_unexpected", int'(gnt), 0);
      end else begin
        mon_eg = exp_gnt.pop_front();
        mon_k  = exp_gidx.pop_front();
        check_eq("gnt", int'(gnt), int'(mon_eg));
        check_eq("gnt_shift_en", int'(shift_en), 1);
        check_eq("gnt_ch_sel", int'(ch_sel), mon_k);
        check_eq("gnt_addr", int'(addr), 0);
        exp_ch.push_back(mon_k);
        exp_at.push_back(cyc + ValDly);
      end
    end
    if (val_out) begin
      if (exp_ch.size() == 0) begin
        check_eq("val_unexpected", int'(val_out), 0);
      end else begin
        mon_ch = exp_ch.pop_front();
        mon_at = exp_at.pop_front();
        check_eq("val_ch_out", int'(ch_out), mon_ch);
        check_eq("val_cycle", cyc, mon_at);
      end
    end
  end

  task automatic wait_gnt(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_eq({tag, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_gnt.size() == 0 && exp_ch.size() == 0 && !busy) break;
    end
    check_eq({tag, "_drain"}, exp_gnt.size() + exp_ch.size(), 0);
  endtask

  // Hold req for n grants, checking pass spacing, then drop it.
  task automatic run_held(input string tag, input logic [3:0] r, input int n);
    int prev, at;
    push_grants(r, n);
    req = r;
    wait_gnt(tag, prev);
    for (int i = 1; i < n; i++) begin
      wait_gnt(tag, at);
      check_eq({tag, "_gap"}, at - prev, Period);
      prev = at;
    end
    req = '0;
    wait_drain(tag);
  endtask

  initial begin
    int rel, at, prev;

    // Reset held with all channels requesting
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", int'(gnt), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ctl", int'({shift_en, acc_rst, acc_ce, val_out}), 0);
    check_eq("rst_addr_ch", int'({addr, ch_sel, ch_out}), 0);

    // Release with all requesting: ch0 first, then round-robin order, 19-cycle spacing
    push_grants(4'b1111, 5);
    rst = 1'b1;
    rel = cyc;
    wait_gnt("t3", prev);
    check_eq("t1_first_gnt_latency", prev - rel, 1);
    for (int i = 1; i < 5; i++) begin
      wait_gnt("t3", at);
      check_eq("t3_gap", at - prev, Period);
      prev = at;
    end
    req = '0;
    wait_drain("t3");

    // Single request on ch2: tap sequence and accumulator control timing
    push_grants(4'b0100, 1);
    req = 4'b0100;
    @(negedge clk);
    check_eq("t2_gnt", int'(gnt), 4'b0100);
    check_eq("t2_busy_grant", int'(busy), 1);
    req = '0;
    for (int i = 0; i < NumCoef; i++) begin
      @(negedge clk);
      check_eq("t2_addr", int'(addr), i);
      check_eq("t2_ch_sel", int'(ch_sel), 2);
      check_eq("t2_acc_rst", int'(acc_rst), int'(i == Lat));
      check_eq("t2_acc_ce", int'(acc_ce), int'(i >= Lat));
    end
    for (int j = NumCoef + 2; j <= NumCoef + Lat + 2; j++) begin
      @(negedge clk);
      check_eq("t2_tail_acc_ce", int'(acc_ce), int'(j <= NumCoef + Lat + 1));
      check_eq("t2_tail_val", int'(val_out), int'(j == NumCoef + Lat + 2));
      check_eq("t2_tail_addr", int'(addr), 0);
    end
    wait_drain("t2");

    // Continuous single requester, then a two-channel contention pattern
    run_held("t4", 4'b0001, 3);
    run_held("t6", 4'b1010, 3);

    // Reset mid-pass: no result for the abandoned pass, ch0 priority restored
    push_grants(4'b0010, 1);
    req = 4'b0010;
    wait_gnt("t5", at);
    req = '0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    exp_ch.delete();
    exp_at.delete();
    mrr = 0;
    #1;
    check_eq("t5_busy", int'(busy), 0);
    check_eq("t5_addr", int'(addr), 0);
    check_eq("t5_ch_sel", int'(ch_sel), 0);
    check_eq("t5_acc_ce", int'(acc_ce), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t5_val_in_rst", int'(val_out), 0);
    end
    rst = 1'b1;
    push_grants(4'b1000, 1);
    req = 4'b1000;
    wait_gnt("t5b", at);
    req = '0;
    wait_drain("t5b");

    check_eq("queues_empty", exp_gnt.size() + exp_ch.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
